// File: rtl/ufm_config_loader.sv
`default_nettype none
// ufm_config_loader: reads the UFM configuration image over Avalon-MM, unpacks it
// into power-supply / signal-generator fields and commits them in a single edge.
// Revision: 1.0
module ufm_config_loader #(
  parameter int         NUM_WORDS = 6,
  parameter logic [3:0] CTRL_READ = 4'h4,
  parameter int         TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  controlstate,
  output logic        ufmread,
  output logic [15:0] read_addr,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic [1:0]  readstate,
  output logic [9:0]  psRef,
  output logic        relay1reset,
  output logic        relay2reset,
  output logic [23:0] sgRefFreq,
  output logic [95:0] sgDP,
  output logic        blank,
  output logic        timeout_err
);

  localparam int c_cnt_w = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int c_to_w  = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(NUM_WORDS - 1);
  localparam logic [c_to_w-1:0]  c_to_last   = c_to_w'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAITDATA = 3'd2,
    ST_NEXT     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [c_cnt_w-1:0]            r_cnt;
  logic [c_to_w-1:0]             r_to;
  logic [NUM_WORDS-1:0][23:0]    r_shadow;
  logic                          r_blank;
  logic                          r_timeout;
  logic [9:0]                    r_psref;
  logic                          r_relay1;
  logic                          r_relay2;
  logic [23:0]                   r_freq;
  logic [95:0]                   r_sgdp;

  logic w_clear;
  logic w_accept;
  logic w_latch;
  logic w_to_inc;
  logic w_to_fire;
  logic w_cnt_inc;
  logic w_commit;
  logic w_unused;

  assign w_clear  = (controlstate == 4'h0);
  // Upper half of word 0 carries no field; keep the sink so it does not look forgotten.
  assign w_unused = ^r_shadow[0][23:12];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_latch     = 1'b0;
    w_to_inc    = 1'b0;
    w_to_fire   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_commit    = 1'b0;
    ufmread     = 1'b0;
    readstate   = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (controlstate == CTRL_READ) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        ufmread   = 1'b1;
        readstate = 2'b01;
        if (!waitrequest) begin
          w_accept = 1'b1;
          // Zero-latency response arriving with the accept is taken immediately.
          if (readdatavalid) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_NEXT;
          end else begin
            w_state_nxt = ST_WAITDATA;
          end
        end
      end
      ST_WAITDATA: begin
        readstate = 2'b01;
        if (readdatavalid) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_NEXT;
        end else if (r_to == c_to_last) begin
          w_to_fire   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_to_inc = 1'b1;
        end
      end
      ST_NEXT: begin
        readstate = 2'b01;
        if (r_cnt < c_last_word) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_commit    = !r_blank && !r_timeout;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        readstate = (r_blank || r_timeout) ? 2'b11 : 2'b10;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_clear) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_to      <= '0;
      r_shadow  <= '0;
      r_blank   <= 1'b0;
      r_timeout <= 1'b0;
      r_psref   <= '0;
      r_relay1  <= 1'b0;
      r_relay2  <= 1'b0;
      r_freq    <= '0;
      r_sgdp    <= '0;
    end else if (w_clear) begin
      r_cnt     <= '0;
      r_to      <= '0;
      r_shadow  <= '0;
      r_blank   <= 1'b0;
      r_timeout <= 1'b0;
      r_psref   <= '0;
      r_relay1  <= 1'b0;
      r_relay2  <= 1'b0;
      r_freq    <= '0;
      r_sgdp    <= '0;
    end else begin
      if (r_state == ST_IDLE) r_cnt <= '0;
      else if (w_cnt_inc)     r_cnt <= r_cnt + 1'b1;

      if (w_accept)      r_to <= '0;
      else if (w_to_inc) r_to <= r_to + 1'b1;

      if (w_to_fire) r_timeout <= 1'b1;

      if (w_latch) begin
        r_shadow[r_cnt] <= readdata[23:0];
        if (readdata == 32'hFFFF_FFFF) r_blank <= 1'b1;
      end

      // All fields load together so consumers never see a mixed image.
      if (w_commit) begin
        r_psref  <= r_shadow[0][9:0];
        r_relay1 <= r_shadow[0][10];
        r_relay2 <= r_shadow[0][11];
        r_freq   <= r_shadow[1];
        for (int j = 0; j < 4; j++) r_sgdp[24*j +: 24] <= r_shadow[2+j];
      end
    end
  end

  assign read_addr   = {{(16-c_cnt_w){1'b0}}, r_cnt};
  assign psRef       = r_psref;
  assign relay1reset = r_relay1;
  assign relay2reset = r_relay2;
  assign sgRefFreq   = r_freq;
  assign sgDP        = r_sgdp;
  assign blank       = r_blank;
  assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ufm_config_loader.sv
`default_nettype none
// tb_ufm_config_loader: randomized Avalon responder with a behavioural image model.
module tb_ufm_config_loader;

  localparam int         NW = 6;
  localparam logic [3:0] CR = 4'h4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  controlstate;
  logic        ufmread;
  logic [15:0] read_addr;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [1:0]  readstate;
  logic [9:0]  psRef;
  logic        relay1reset;
  logic        relay2reset;
  logic [23:0] sgRefFreq;
  logic [95:0] sgDP;
  logic        blank;
  logic        timeout_err;

  ufm_config_loader #(.NUM_WORDS(NW), .CTRL_READ(CR), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset_n(reset_n), .controlstate(controlstate),
    .ufmread(ufmread), .read_addr(read_addr), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .readstate(readstate),
    .psRef(psRef), .relay1reset(relay1reset), .relay2reset(relay2reset),
    .sgRefFreq(sgRefFreq), .sgDP(sgDP), .blank(blank), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [31:0]  m_mem [NW];
  int           m_wait [NW];
  int           m_lat [NW];
  int           m_noval;
  int           m_abort_at;
  int           m_abort_kind;
  logic [131:0] model_fields;
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [131:0] dut_fields();
    return {psRef, relay1reset, relay2reset, sgRefFreq, sgDP};
  endfunction

  // Field image as the configuration layout defines it, one 12-bit sgDP slot at a time.
  function automatic logic [131:0] unpack_img();
    logic [9:0]  ps;
    logic        r1, r2;
    logic [23:0] fr;
    logic [95:0] dp;
    logic [31:0] w;
    ps = 10'(m_mem[0] % 1024);
    r1 = 1'((m_mem[0] >> 10) & 1);
    r2 = 1'((m_mem[0] >> 11) & 1);
    fr = 24'(m_mem[1] % 32'h0100_0000);
    dp = '0;
    for (int k = 0; k < 8; k++) begin
      w = m_mem[2 + k/2];
      if (k % 2 == 1) dp[12*k +: 12] = 12'((w >> 12) % 4096);
      else            dp[12*k +: 12] = 12'(w % 4096);
    end
    return {ps, r1, r2, fr, dp};
  endfunction

  task automatic chk_idle(input string tag);
    check({tag, ":ufmread"}, ufmread, 1'b0);
    check({tag, ":readstate"}, readstate, 2'b00);
    check({tag, ":fields"}, dut_fields(), model_fields);
    check({tag, ":blank"}, blank, 1'b0);
    check({tag, ":timeout"}, timeout_err, 1'b0);
  endtask

  task automatic do_clear();
    controlstate  = 4'h0;
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    @(posedge clk); #1;
    model_fields = '0;
    chk_idle("clear");
  endtask

  task automatic set_nominal();
    m_mem[0] = 32'h0000_00C3;
    m_mem[1] = 32'h004C_4B40;
    for (int k = 2; k < NW; k++) m_mem[k] = 32'h0010_0100;
    for (int k = 0; k < NW; k++) begin
      m_wait[k] = 0;
      m_lat[k]  = 1;
    end
    m_noval    = -1;
    m_abort_at = -1;
  endtask

  task automatic run_load(input string tag, input bit chk_lat);
    int           n, accepted, cd, cur, wleft, noval_acc, to_edge, changes;
    bit           done, wr_prev, exp_blank, exp_to, ok;
    logic [15:0]  addr_prev;
    logic [131:0] exp_f, last_f;
    exp_blank = 1'b0;
    exp_to    = (m_noval >= 0);
    for (int k = 0; k < NW; k++)
      if ((m_noval < 0 || k < m_noval) && m_mem[k] == 32'hFFFF_FFFF) exp_blank = 1'b1;
    ok    = !exp_blank && !exp_to;
    exp_f = ok ? unpack_img() : model_fields;
    n = 0; accepted = 0; cd = -1; cur = 0; wleft = m_wait[0];
    noval_acc = -1; to_edge = -1; changes = 0; done = 1'b0; wr_prev = 1'b0; addr_prev = '0;
    last_f = dut_fields();
    controlstate  = CR;
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (dut_fields() !== last_f) changes++;
      last_f = dut_fields();
      if (timeout_err && to_edge < 0) to_edge = n;
      if (wr_prev) begin
        check({tag, ":hold_rd"}, ufmread, 1'b1);
        check({tag, ":hold_addr"}, read_addr, addr_prev);
      end
      waitrequest   = 1'b0;
      readdatavalid = 1'b0;
      readdata      = $urandom;
      wr_prev       = 1'b0;
      if (readstate[1]) begin
        done = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          readdatavalid = 1'b1;
          readdata      = m_mem[cur];
          cd            = -1;
        end
      end else if (ufmread) begin
        check({tag, ":addr"}, read_addr, 16'(accepted));
        if (accepted == m_abort_at) begin
          if (m_abort_kind == 1) begin
            controlstate = 4'h0;
            @(posedge clk); #1;
            model_fields = '0;
            chk_idle({tag, ":abort"});
          end else begin
            #2 reset_n = 1'b0;
            #1;
            model_fields = '0;
            chk_idle({tag, ":arst"});
            controlstate = 4'h2;
            @(negedge clk);
            reset_n = 1'b1;
          end
          return;
        end
        if (wleft > 0) begin
          waitrequest = 1'b1;
          wleft--;
          wr_prev   = 1'b1;
          addr_prev = read_addr;
        end else begin
          cur = accepted;
          accepted++;
          if (cur == m_noval) begin
            noval_acc = n + 1;
          end else if (m_lat[cur] == 0) begin
            readdatavalid = 1'b1;
            readdata      = m_mem[cur];
          end else begin
            cd = m_lat[cur];
          end
          if (accepted < NW) wleft = m_wait[accepted];
        end
      end
    end
    check({tag, ":finished"}, done, 1'b1);
    check({tag, ":readstate"}, readstate, ok ? 2'b10 : 2'b11);
    check({tag, ":blank"}, blank, exp_blank);
    check({tag, ":timeout"}, timeout_err, exp_to);
    check({tag, ":fields"}, dut_fields(), exp_f);
    check({tag, ":words_read"}, accepted, exp_to ? m_noval + 1 : NW);
    check({tag, ":commit_edges"}, changes, (exp_f !== model_fields) ? 1 : 0);
    if (chk_lat) check({tag, ":latency"}, n, 19);
    if (exp_to) check({tag, ":to_delay"}, to_edge - noval_acc, 255);
    model_fields = exp_f;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    controlstate  = 4'h0;
    waitrequest   = 1'b0;
    readdata      = '0;
    readdatavalid = 1'b0;
    m_noval       = -1;
    m_abort_at    = -1;
    m_abort_kind  = 0;
    model_fields  = '0;
    for (int k = 0; k < NW; k++) begin
      m_mem[k] = '0; m_wait[k] = 0; m_lat[k] = 1;
    end
    #12;
    chk_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;

    controlstate = 4'h2;
    repeat (4) begin
      @(posedge clk); #1;
      readdatavalid = 1'b1;
      readdata      = $urandom;
    end
    @(posedge clk); #1;
    readdatavalid = 1'b0;
    chk_idle("stray_idle");

    set_nominal();
    run_load("nominal", 1'b1);
    check("nom_psref", psRef, 10'h0C3);
    check("nom_relays", {relay1reset, relay2reset}, 2'b00);
    check("nom_freq", sgRefFreq, 24'h4C4B40);
    check("nom_sgdp", sgDP, {8{12'h100}});

    controlstate = 4'h2;
    repeat (3) @(posedge clk);
    #1;
    controlstate = CR;
    repeat (3) begin
      readdatavalid = 1'b1;
      readdata      = 32'hFFFF_FFFF;
      @(posedge clk); #1;
    end
    readdatavalid = 1'b0;
    check("done_sticky:readstate", readstate, 2'b10);
    check("done_sticky:ufmread", ufmread, 1'b0);
    check("done_sticky:fields", dut_fields(), model_fields);

    #2 reset_n = 1'b0;
    #1;
    model_fields = '0;
    chk_idle("arst_done");
    controlstate = 4'h2;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("after_arst");

    do_clear();
    set_nominal();
    m_wait[3] = 5;
    run_load("wait3", 1'b0);
    check("wait3_vs_nominal", dut_fields(), unpack_img());

    do_clear();
    set_nominal();
    m_mem[2] = 32'hFFFF_FFFF;
    run_load("blank", 1'b0);

    do_clear();
    set_nominal();
    m_noval = 1;
    run_load("timeout", 1'b0);

    do_clear();
    set_nominal();
    m_abort_at   = 4;
    m_abort_kind = 1;
    run_load("abort", 1'b0);
    m_abort_at = -1;
    run_load("restart", 1'b0);

    do_clear();
    set_nominal();
    m_abort_at   = 2;
    m_abort_kind = 2;
    run_load("arst_mid", 1'b0);
    m_abort_at = -1;
    readdatavalid = 1'b1;
    readdata      = $urandom;
    @(posedge clk); #1;
    readdatavalid = 1'b0;
    chk_idle("arst_mid_idle");

    for (int i = 0; i < 24; i++) begin
      do_clear();
      for (int k = 0; k < NW; k++) begin
        m_mem[k]  = $urandom;
        m_wait[k] = $urandom_range(0, 3);
        m_lat[k]  = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 7) == 0) m_mem[$urandom_range(0, NW-1)] = 32'hFFFF_FFFF;
      m_noval    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NW-1)) : -1;
      m_abort_at = -1;
      run_load($sformatf("rnd%0d", i), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ufm_config_loader.md
Name: ufm_config_loader

Overview:
Downstream consumer of the UFM configuration image written by the UFM write stage. On command it reads UFM words 0..5 over the Avalon-MM data port. It unpacks them into the psRef, relay-reset, sgRefFreq and sgDP[0..7] fields, then commits all fields to its outputs in a single cycle. It sits between the on-chip flash data port and the power-supply and signal-generator control logic.

Parameters:
NUM_WORDS, 6, number of UFM words read (addresses 0..NUM_WORDS-1)
CTRL_READ, 4'h4, controlstate value that enables the load
TIMEOUT, 255, maximum cycles to wait for readdatavalid after a read is accepted

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
controlstate  in  4  top-level control FSM state; 4'h0 = synchronous clear, CTRL_READ = run load
ufmread  out  1  Avalon read request
read_addr  out  16  Avalon word address
waitrequest  in  1  UFM busy; holds the current request
readdata  in  32  UFM read data
readdatavalid  in  1  readdata is valid this cycle
readstate  out  2  00 idle, 01 busy, 10 done-ok, 11 done-error
psRef  out  10  committed word0[9:0]
relay1reset  out  1  committed word0[10]
relay2reset  out  1  committed word0[11]
sgRefFreq  out  24  committed word1[23:0]
sgDP  out  96  sgDP[k] = bits[12k+11:12k]; word(2+j)[11:0] -> sgDP[2j], word(2+j)[23:12] -> sgDP[2j+1]
blank  out  1  a word read back as 32'hFFFFFFFF (erased flash)
timeout_err  out  1  readdatavalid missing for TIMEOUT cycles

Behaviour:
- reset_n low (async): ufmread=0, read_addr=0, readstate=00, all field outputs 0, blank=0, timeout_err=0, word counter 0, shadow registers 0, FSM IDLE.
- controlstate==4'h0 (sync): same values as async reset, applied on the next clock edge. Takes priority over all other activity, including mid-transfer aborts. ufmread drops the next cycle.
- FSM states: IDLE, ISSUE, WAITDATA, NEXT, DONE.
- IDLE: when controlstate==CTRL_READ, go to ISSUE with counter 0. readstate=01 from ISSUE until DONE.
- ISSUE: ufmread=1, read_addr=counter. Hold both stable while waitrequest=1. On the first edge with waitrequest=0, the read is accepted: ufmread=0 next cycle, timeout counter cleared, go to WAITDATA.
- WAITDATA: readdatavalid=1 -> latch readdata into shadow[counter], go to NEXT.
  - If readdata==32'hFFFFFFFF, also set blank.
  - readdatavalid in the same cycle the read is accepted is also valid: latch it and go directly to NEXT.
  - Otherwise increment the timeout counter. At TIMEOUT with no valid, set timeout_err and go to DONE.
- NEXT: if counter < NUM_WORDS-1, increment counter and go to ISSUE. Otherwise go to DONE.
  - If blank==0 and timeout_err==0, commit: all field outputs load from shadow in the same edge.
  - Outputs never show a partial mix of old and new words.
- DONE: readstate=10 on success, 11 if blank or timeout_err. Stay in DONE until controlstate==4'h0.
  - Leaving CTRL_READ without passing through 4'h0 does not restart the load.
- Minimum load latency with zero wait states and readdatavalid one cycle after acceptance: 3 cycles per word; readstate=10 at cycle 19 after entry to CTRL_READ.
- readdatavalid in IDLE, NEXT or DONE is ignored.
- Bits word0[31:12], word1[31:24] and word(2..5)[31:24] are ignored.
- Avalon rule: exactly one outstanding read at a time. read_addr never changes while ufmread=1 and waitrequest=1.

Test Plan:
- Nominal image (w0=32'h000000C3, w1=32'h004C4B40, w2..w5=32'h00100100), zero waits, 1-cycle latency -> psRef=10'h0C3, relays 0, sgRefFreq=24'h4C4B40, every sgDP[k]=12'h100, readstate=10, outputs change in one edge.
- waitrequest held high 5 cycles on address 3 -> ufmread and read_addr=3 stable throughout, final values identical to nominal.
- w2 returns 32'hFFFFFFFF -> blank=1, readstate=11, field outputs keep previous committed values.
- readdatavalid withheld after address 1 is accepted -> timeout_err=1 after 255 cycles, readstate=11, no commit.
- controlstate forced to 4'h0 mid-read of word 4 -> next edge ufmread=0 and all outputs 0. Returning to CTRL_READ restarts from address 0 and completes correctly.
- reset_n pulsed low asynchronously mid-transfer -> outputs 0 immediately, without waiting for a clock edge. Stray readdatavalid in IDLE is ignored.
